// File: rtl/mem_array.sv
// WIDTH x DEPTH single-clock array: one write port, one registered read port, init sweep after reset/clr_req.
// Latency: read data and rd_valid 1 cycle after rd_en; a write is visible to the next read; a sweep takes DEPTH cycles.
// Backpressure: accesses and clr_req are only accepted while ready=1; strobes during a sweep are dropped.
module mem_array #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 16,
    parameter int               ADDR_W   = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic              addr_err
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ic, ic_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wr_in_range, rd_in_range;
    logic              wr_acc, rd_acc, clr_acc, err_set;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign ready       = (state == ST_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ic    <= '0;
        end else begin
            state <= state_nxt;
            ic    <= ic_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ic_nxt    = ic;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        clr_acc   = 1'b0;
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ic;
                mem_wdata = INIT_VAL;
                if (ic == LAST_IDX) begin
                    state_nxt = ST_READY;
                    ic_nxt    = '0;
                end else begin
                    ic_nxt = ic + ADDR_W'(1);
                end
            end
            ST_READY: begin
                wr_acc  = wr_en && wr_in_range;
                rd_acc  = rd_en && rd_in_range;
                err_set = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
                mem_we  = wr_acc;
                // Accesses on the accepting edge still complete; the sweep starts on the next edge.
                if (clr_req) begin
                    clr_acc   = 1'b1;
                    state_nxt = ST_INIT;
                    ic_nxt    = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Storage is deliberately not reset; the sweep gives it a defined value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= (wr_acc && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
            end
            if (clr_acc) begin
                addr_err <= 1'b0;
            end else if (err_set) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule
